alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 219 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith/shift/compare ops and iterative unsigned mul/div.
// Define ALU_SIGNED_MULDIV_EN to add signed MULH (1011), DIV (1110) and REM (1111).
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHI = 4'b1011;  // MULHU, or signed MULH when enabled
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;
`ifdef ALU_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_REM   = 4'b1111;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt, cnt_dec;
    logic [3:0]         op_q;

    logic             accept, start_iter, res_load;
    logic [WIDTH-1:0] res_val, fin;
    logic             is_mul_op, is_div_op, is_quot, div_special;
    logic [WIDTH-1:0] special_val, a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
`ifdef ALU_SIGNED_MULDIV_EN
    logic             neg_q, neg_next;
`endif

    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SH_W-1:0]         sh;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = sa >>> sh;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return -v;
    endfunction

    // Request decode: operand magnitudes, sign of result, and cases that finish immediately
    always_comb begin
        a_mag       = A;
        b_mag       = B;
        div_special = 1'b0;
        special_val = A;
        is_mul_op   = (ALUControl_in == OP_MUL) || (ALUControl_in == OP_MULHI);
        is_div_op   = (ALUControl_in == OP_DIVU) || (ALUControl_in == OP_REMU);
        is_quot     = (ALUControl_in == OP_DIVU);
`ifdef ALU_SIGNED_MULDIV_EN
        neg_next    = 1'b0;
        is_div_op   = is_div_op || (ALUControl_in == OP_DIV) || (ALUControl_in == OP_REM);
        is_quot     = is_quot || (ALUControl_in == OP_DIV);
        if (ALUControl_in == OP_MULHI || ALUControl_in == OP_DIV || ALUControl_in == OP_REM) begin
            a_mag    = A[WIDTH-1] ? negate(A) : A;
            b_mag    = B[WIDTH-1] ? negate(B) : B;
            neg_next = (ALUControl_in == OP_REM) ? A[WIDTH-1] : (A[WIDTH-1] ^ B[WIDTH-1]);
        end
        if ((ALUControl_in == OP_DIV || ALUControl_in == OP_REM) &&
            A == {1'b1, {(WIDTH-1){1'b0}}} && B == {WIDTH{1'b1}}) begin
            div_special = 1'b1;
            special_val = (ALUControl_in == OP_DIV) ? A : '0;
        end
`endif
        if (is_div_op && B == '0) begin
            div_special = 1'b1;
            special_val = is_quot ? {WIDTH{1'b1}} : A;
        end
    end

    // Iteration step: shift-add multiply or restoring divide, plus final result selection
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand};
        div_diff  = div_shift[WIDTH-1:0] - mcand;
        if (state == DIV)
            acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        cnt_dec = cnt - CNT_W'(1);

        case (op_q)
            OP_MUL:  fin = acc_step[WIDTH-1:0];
`ifdef ALU_SIGNED_MULDIV_EN
            // high half of the negated product: ~hi plus the carry out of -lo
            OP_MULHI: fin = neg_q ? (~acc_step[2*WIDTH-1:WIDTH] +
                                     {{(WIDTH-1){1'b0}}, (acc_step[WIDTH-1:0] == '0)})
                                  : acc_step[2*WIDTH-1:WIDTH];
            OP_DIV:  fin = neg_q ? negate(acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];
            OP_REM:  fin = neg_q ? negate(acc_step[2*WIDTH-1:WIDTH]) : acc_step[2*WIDTH-1:WIDTH];
`else
            OP_MULHI: fin = acc_step[2*WIDTH-1:WIDTH];
`endif
            OP_REMU: fin = acc_step[2*WIDTH-1:WIDTH];
            default: fin = acc_step[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        accept     = in_valid & in_ready;
        start_iter = 1'b0;
        res_load   = 1'b0;
        res_val    = ALU_result;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((is_mul_op || is_div_op) && !div_special) begin
                        start_iter = 1'b1;
                        state_next = is_mul_op ? MUL : DIV;
                    end else begin
                        res_load   = 1'b1;
                        res_val    = div_special ? special_val : single_op(ALUControl_in, A, B);
                        state_next = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt_dec == '0) begin
                    res_load   = 1'b1;
                    res_val    = fin;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            mcand      <= '0;
            cnt        <= '0;
            op_q       <= '0;
            ALU_result <= '0;
            zero       <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            if (start_iter) begin
                // mul: multiplier in the low half, multiplicand aside; div: dividend low, divisor aside
                acc   <= {{WIDTH{1'b0}}, (is_mul_op ? b_mag : a_mag)};
                mcand <= is_mul_op ? a_mag : b_mag;
                cnt   <= CNT_W'(WIDTH);
                op_q  <= ALUControl_in;
`ifdef ALU_SIGNED_MULDIV_EN
                neg_q <= neg_next;
`endif
            end else if (state == MUL || state == DIV) begin
                acc <= acc_step;
                cnt <= cnt_dec;
            end
            if (res_load) begin
                ALU_result <= res_val;
                zero       <= (res_val == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results/latencies are queued at issue and checked on out_valid.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [3:0]   ALUControl_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_result;
    logic         zero;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           checks = 0;
    int           failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl_in(ALUControl_in), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_result(ALU_result), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [W-1:0]   sa, sb;
        logic [2*W-1:0]        p;
        logic signed [2*W-1:0] sp;
        logic [W-1:0]          r;
        sa = a; sb = b;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0011: r = a ^ b;
            4'b0100: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b0111: r = sa >>> b[4:0];
            4'b1000: r = (sa < sb) ? 1 : 0;
            4'b1001: r = (a < b) ? 1 : 0;
            4'b1010: r = p[W-1:0];
`ifdef ALU_SIGNED_MULDIV_EN
            4'b1011: r = sp[2*W-1:W];
            4'b1110: r = (b == 0) ? '1 : (a == 32'h8000_0000 && b == '1) ? a : sa / sb;
            4'b1111: r = (b == 0) ? a : (a == 32'h8000_0000 && b == '1) ? '0 : sa % sb;
`else
            4'b1011: r = p[2*W-1:W];
`endif
            4'b1100: r = (b == 0) ? '1 : a / b;
            4'b1101: r = (b == 0) ? a : a % b;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int l;
        l = 1;
        if (op == 4'b1010 || op == 4'b1011) l = W + 1;
        if ((op == 4'b1100 || op == 4'b1101) && b != 0) l = W + 1;
`ifdef ALU_SIGNED_MULDIV_EN
        if ((op == 4'b1110 || op == 4'b1111) && b != 0 && !(a == 32'h8000_0000 && b == '1)) l = W + 1;
`endif
        return l;
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL send_ready in_ready=%b required=1", in_ready);
        end
        exp_q.push_back(model(op, a, b));
        lat_q.push_back(latency(op, a, b));
        A = a; B = b; ALUControl_in = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ALUControl_in = 4'($urandom);
    endtask

    task automatic collect(output logic [W-1:0] r, output logic z, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        r = ALU_result; z = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALU_result !== '0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%b res=%h z=%b required v=0 r=1 res=0 z=0",
                     out_valid, in_ready, ALU_result, zero);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        logic [3:0]   ops[13] = '{4'b0110, 4'b0111, 4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b0100,
                                  4'b0101, 4'b1000, 4'b1001, 4'b1000, 4'b0010, 4'b0100};
        logic [W-1:0] as[13]  = '{32'd5, 32'h8000_0000, 32'd3, 32'hF0F0_1234, 32'h0F00_0001,
                                  32'hFFFF_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [W-1:0] bs[13]  = '{32'd5, 32'd4, 32'd4, 32'h0FF0_FFFF, 32'h00F0_0010,
                                  32'h0F0F_00FF, 32'd31, 32'd31, 32'd1, 32'd1, 32'hFFFF_FFFF,
                                  32'd1, 32'hFFFF_FFE4};
        logic [W-1:0] r, e;
        logic         z;
        int           lat, el;
        for (int i = 0; i < 13; i++) begin
            send(ops[i], as[i], bs[i]);
            collect(r, z, lat);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (r !== e || z !== (e == 0) || lat !== el) begin
                failures++;
                $display("FAIL single op=%b got res=%h z=%b lat=%0d required res=%h z=%b lat=%0d",
                         ops[i], r, z, lat, e, (e == 0), el);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]   ops[8] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1100, 4'b1101, 4'b1010, 4'b1100};
        logic [W-1:0] as[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd9,
                                 32'd0, 32'hFFFF_FFFF};
        logic [W-1:0] bs[8]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd12345, 32'd1};
        logic [W-1:0] r, e;
        logic         z;
        int           lat, el;
        for (int i = 0; i < 8; i++) begin
            send(ops[i], as[i], bs[i]);
            collect(r, z, lat);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (r !== e || z !== (e == 0) || lat !== el) begin
                failures++;
                $display("FAIL muldiv op=%b a=%h b=%h got res=%h z=%b lat=%0d required res=%h z=%b lat=%0d",
                         ops[i], as[i], bs[i], r, z, lat, e, (e == 0), el);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r, e;
        logic [3:0]   op;
        logic         z;
        int           lat, el;
        for (int i = 0; i < 10; i++) begin
`ifdef ALU_SIGNED_MULDIV_EN
            op = 4'(10 + $urandom_range(0, 5));
`else
            op = 4'(10 + $urandom_range(0, 3));
`endif
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            send(op, a, b);
            collect(r, z, lat);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (r !== e || z !== (e == 0) || lat !== el) begin
                failures++;
                $display("FAIL random op=%b a=%h b=%h got res=%h lat=%0d required res=%h lat=%0d",
                         op, a, b, r, lat, e, el);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] held, e;
        int           lat, el;
        out_ready = 1'b0;
        send(4'b0010, 32'd1, 32'd2);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        held = ALU_result;
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (held !== e || lat !== el) begin
            failures++;
            $display("FAIL bp_result got res=%h lat=%0d required res=%h lat=%0d", held, lat, e, el);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; A = $urandom; B = $urandom; ALUControl_in = 4'b0010;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALU_result !== e || zero !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got v=%b r=%b res=%h z=%b required v=1 r=0 res=%h z=0",
                         i, out_valid, in_ready, ALU_result, zero, e);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got v=%b r=%b required v=0 r=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_ghost got v=%b required v=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] r, e;
        logic         z;
        int           lat, el;
        A = 32'hFFFF_FFFF; B = 32'd2; ALUControl_in = 4'b1010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALU_result !== '0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got v=%b r=%b res=%h z=%b required v=0 r=1 res=0 z=0",
                     out_valid, in_ready, ALU_result, zero);
        end
        send(4'b0010, 32'd3, 32'd4);
        collect(r, z, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (r !== e || z !== 1'b0 || lat !== el) begin
            failures++;
            $display("FAIL after_reset_add got res=%h z=%b lat=%0d required res=%h z=0 lat=%0d",
                     r, z, lat, e, el);
        end
    endtask

    task automatic test_spare_opcodes();
`ifdef ALU_SIGNED_MULDIV_EN
        logic [3:0]   ops[5] = '{4'b1110, 4'b1111, 4'b1110, 4'b1111, 4'b1011};
        logic [W-1:0] as[5]  = '{-32'sd7, -32'sd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [W-1:0] want[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
`else
        logic [3:0]   ops[5] = '{4'b1110, 4'b1111, 4'b1110, 4'b1111, 4'b1011};
        logic [W-1:0] as[5]  = '{-32'sd7, -32'sd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        logic [W-1:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        logic [W-1:0] want[5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd0, 32'hFFFF_FFFE};
`endif
        logic [W-1:0] r, e;
        logic         z;
        int           lat, el;
        for (int i = 0; i < 5; i++) begin
            send(ops[i], as[i], bs[i]);
            collect(r, z, lat);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (r !== want[i] || e !== want[i] || z !== (want[i] == 0) || lat !== el) begin
                failures++;
                $display("FAIL spare op=%b got res=%h z=%b lat=%0d required res=%h z=%b lat=%0d",
                         ops[i], r, z, lat, want[i], (want[i] == 0), el);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALUControl_in = '0;
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_spare_opcodes();
        test_back_pressure();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
